pulse_handshake_tx: RTL

Source-clock-domain transmitter for a toggle-based pulse crossing with acknowledge. It converts single-cycle event pulses on `in` into level toggles on `req_tgl`. It waits for the destination's returned `ack_tgl` toggle, synchronized locally, before launching the next event. Events arriving while a transfer is in flight are counted and drained in order, so no pulse is lost until the pending counter saturates.

---
 rtl/pulse_handshake_tx.sv | 69 ++++++
 1 files changed

// File: rtl/pulse_handshake_tx.sv
// pulse_handshake_tx: source side of a toggle req/ack pulse crossing with a queued-event counter
module pulse_handshake_tx #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in,
   input  logic             ack_tgl,
   input  logic             clr_ovf,
   output logic             req_tgl,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pending,
   output logic             overflow
);
   localparam logic [CNT_W-1:0] MAX = '1;
   typedef enum logic {IDLE, WAIT} state_t;
   state_t state, state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0] pend_nxt;
   logic [CNT_W:0] total;
   logic ack_s, req_nxt, done_nxt, ovf_nxt, drop;
   assign ack_s = sync[SYNC_STAGES-1];
   assign busy = state == WAIT;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         sync     <= '0;
         req_tgl  <= 1'b0;
         pending  <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         sync     <= {sync[SYNC_STAGES-2:0], ack_tgl};
         req_tgl  <= req_nxt;
         pending  <= pend_nxt;
         done     <= done_nxt;
         overflow <= ovf_nxt;
      end
   end
   // a new event landing on the completion cycle is queued, then launched from IDLE next edge
   always_comb begin
      total     = {1'b0, pending} + (CNT_W+1)'(in);
      state_nxt = state;
      req_nxt   = req_tgl;
      pend_nxt  = pending;
      done_nxt  = 1'b0;
      drop      = 1'b0;
      if (state == IDLE) begin
         if (total != '0) begin
            req_nxt   = ~req_tgl;
            pend_nxt  = CNT_W'(total - 1'b1);
            state_nxt = WAIT;
         end
      end else begin
         if (ack_s == req_tgl) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
         if (in) begin
            pend_nxt = (pending != MAX) ? pending + 1'b1 : pending;
            drop     = pending == MAX;
         end
      end
      ovf_nxt = drop | (overflow & ~clr_ovf);
   end
endmodule
